// File: rtl/nand_dq_rd_calib.sv
// nand_dq_rd_calib: sweeps the shared DQ IODELAY, finds the first passing window of the read training pattern, parks at its centre.
// Latency ~SETTLE_CYC+NUM_SAMPLES cycles per tap; rd_valid gaps stretch a tap up to TIMEOUT_CYC. Debug ports: NAND_CALIB_DBG_EN.
module nand_dq_rd_calib #(
  parameter int                   DQ_WIDTH     = 8,
  parameter int                   MAX_TAP      = 63,
  parameter int                   SETTLE_CYC   = 8,
  parameter int                   NUM_SAMPLES  = 16,
  parameter int                   TIMEOUT_CYC  = 1024,
  parameter int                   MIN_WINDOW   = 4,
  parameter logic [DQ_WIDTH-1:0]  PATTERN_RISE = 8'hA5,
  parameter logic [DQ_WIDTH-1:0]  PATTERN_FALL = 8'h5A
) (
  input  logic                v_clk90,
  input  logic                v_rstn90,
  input  logic                calib_start,
  input  logic                rd_valid,
  input  logic [DQ_WIDTH-1:0] v_rd_data_rise,
  input  logic [DQ_WIDTH-1:0] v_rd_data_fall,
  output logic [DQ_WIDTH-1:0] v_dlyinc_dq,
  output logic [DQ_WIDTH-1:0] v_dlyce_dq,
  output logic                v_dq_oe_n,
  output logic                v_dqs_oe_n,
  output logic                calib_busy,
  output logic                calib_done,
  output logic                calib_fail,
  output logic [5:0]          calib_tap
`ifdef NAND_CALIB_DBG_EN
  ,
  output logic [5:0]          dbg_win_first,
  output logic [5:0]          dbg_win_last,
  output logic [2:0]          dbg_state,
  output logic [MAX_TAP:0]    dbg_tap_pass
`endif
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int NW = $clog2(NUM_SAMPLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [5:0] TAP_MAX = 6'(MAX_TAP);

  typedef enum logic [2:0] {
    S_IDLE, S_REWIND, S_STEP, S_SETTLE, S_SAMPLE, S_CENTER, S_DONE, S_FAIL
  } state_t;

  state_t        state;
  logic [5:0]    cur_tap;
  logic [5:0]    target;
  logic [5:0]    win_first;
  logic [5:0]    win_last;
  logic          in_window;
  logic          tap_ok;
  logic          fail_pending;
  logic          dlyce_q;
  logic          dlyinc_q;
  logic [SW-1:0] settle_cnt;
  logic [NW-1:0] sample_cnt;
  logic [TW-1:0] timeout_cnt;

  logic          match;
  logic          pass_now;
  logic          sample_last;
  logic [5:0]    eff_first;
  logic [5:0]    eff_last;
  logic          eff_in_win;
  logic          win_closed;
  logic [6:0]    win_len;
  logic          win_ok;
  logic [5:0]    eff_target;

  assign match       = (v_rd_data_rise == PATTERN_RISE) && (v_rd_data_fall == PATTERN_FALL);
  assign pass_now    = tap_ok && match;
  assign sample_last = rd_valid && (sample_cnt == NW'(NUM_SAMPLES - 1));

  // Window bookkeeping as it will stand once the current tap's verdict is folded in.
  always_comb begin
    eff_first  = win_first;
    eff_last   = win_last;
    eff_in_win = in_window;
    win_closed = 1'b0;
    if (pass_now) begin
      if (!in_window) begin
        eff_first  = cur_tap;
        eff_in_win = 1'b1;
      end
      eff_last = cur_tap;
    end else if (in_window) begin
      win_closed = 1'b1;
    end
  end

  assign win_len    = {1'b0, eff_last} - {1'b0, eff_first} + 7'd1;
  assign win_ok     = eff_in_win && (win_len >= 7'(MIN_WINDOW));
  assign eff_target = 6'(({1'b0, eff_first} + {1'b0, eff_last}) >> 1);

  assign v_dlyce_dq  = {DQ_WIDTH{dlyce_q}};
  assign v_dlyinc_dq = {DQ_WIDTH{dlyinc_q}};
  assign v_dq_oe_n   = 1'b1;
  assign v_dqs_oe_n  = 1'b1;
  assign calib_tap   = cur_tap;

`ifdef NAND_CALIB_DBG_EN
  assign dbg_win_first = win_first;
  assign dbg_win_last  = win_last;
  assign dbg_state     = state;
`endif

  always_ff @(posedge v_clk90 or negedge v_rstn90) begin
    if (!v_rstn90) begin
      state        <= S_IDLE;
      cur_tap      <= '0;
      target       <= '0;
      win_first    <= '0;
      win_last     <= '0;
      in_window    <= 1'b0;
      tap_ok       <= 1'b0;
      fail_pending <= 1'b0;
      dlyce_q      <= 1'b0;
      dlyinc_q     <= 1'b0;
      settle_cnt   <= '0;
      sample_cnt   <= '0;
      timeout_cnt  <= '0;
      calib_busy   <= 1'b0;
      calib_done   <= 1'b0;
      calib_fail   <= 1'b0;
`ifdef NAND_CALIB_DBG_EN
      dbg_tap_pass <= '0;
`endif
    end else begin
      dlyce_q  <= 1'b0;
      dlyinc_q <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          state <= S_IDLE;
          if (calib_start) begin
            calib_busy   <= 1'b1;
            calib_done   <= 1'b0;
            calib_fail   <= 1'b0;
            fail_pending <= 1'b0;
            in_window    <= 1'b0;
            win_first    <= '0;
            win_last     <= '0;
`ifdef NAND_CALIB_DBG_EN
            dbg_tap_pass <= '0;
`endif
            state <= (cur_tap != 6'd0) ? S_REWIND : S_SETTLE;
          end
        end

        S_REWIND: begin
          if (cur_tap != 6'd0) begin
            dlyce_q <= 1'b1;
            cur_tap <= cur_tap - 6'd1;
          end else if (fail_pending) begin
            calib_busy <= 1'b0;
            calib_fail <= 1'b1;
            state      <= S_FAIL;
          end else begin
            state <= S_SETTLE;
          end
        end

        S_STEP: begin
          state <= S_SETTLE;
        end

        S_SETTLE: begin
          sample_cnt  <= '0;
          timeout_cnt <= '0;
          tap_ok      <= 1'b1;
          settle_cnt  <= settle_cnt + SW'(1);
          if (settle_cnt == SW'(SETTLE_CYC - 1)) begin
            settle_cnt <= '0;
            state      <= S_SAMPLE;
          end
        end

        S_SAMPLE: begin
          timeout_cnt <= timeout_cnt + TW'(1);
          if (rd_valid) begin
            sample_cnt <= sample_cnt + NW'(1);
            if (!match) tap_ok <= 1'b0;
          end
          if (sample_last) begin
            win_first <= eff_first;
            win_last  <= eff_last;
            in_window <= eff_in_win;
`ifdef NAND_CALIB_DBG_EN
            if (pass_now) dbg_tap_pass[cur_tap] <= 1'b1;
`endif
            if (!win_closed && (cur_tap < TAP_MAX)) begin
              // Pulse on entry so the inc is visible while in STEP.
              dlyce_q  <= 1'b1;
              dlyinc_q <= 1'b1;
              cur_tap  <= cur_tap + 6'd1;
              state    <= S_STEP;
            end else if (win_ok) begin
              target <= eff_target;
              state  <= S_CENTER;
            end else begin
              fail_pending <= 1'b1;
              state        <= S_REWIND;
            end
          end else if (timeout_cnt == TW'(TIMEOUT_CYC - 1)) begin
            fail_pending <= 1'b1;
            state        <= S_REWIND;
          end
        end

        S_CENTER: begin
          if (cur_tap != target) begin
            dlyce_q <= 1'b1;
            cur_tap <= cur_tap - 6'd1;
          end else begin
            calib_busy <= 1'b0;
            calib_done <= 1'b1;
            state      <= S_DONE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nand_dq_rd_calib.sv
// Bench for nand_dq_rd_calib: IODELAY/NAND data model, window-based reference model, scoreboard on busy fall.
module tb_nand_dq_rd_calib;
  localparam int MAXT   = 63;
  localparam int SETTLE = 8;
  localparam int TMO    = 1024;
  localparam int MINW   = 4;
  localparam logic [7:0] PR = 8'hA5;
  localparam logic [7:0] PF = 8'h5A;

  logic       v_clk90 = 1'b0;
  logic       v_rstn90 = 1'b0;
  logic       calib_start = 1'b0;
  logic       rd_valid = 1'b0;
  logic [7:0] v_rd_data_rise = '0;
  logic [7:0] v_rd_data_fall = '0;
  logic [7:0] v_dlyinc_dq;
  logic [7:0] v_dlyce_dq;
  logic       v_dq_oe_n;
  logic       v_dqs_oe_n;
  logic       calib_busy;
  logic       calib_done;
  logic       calib_fail;
  logic [5:0] calib_tap;

  nand_dq_rd_calib dut (
    .v_clk90(v_clk90), .v_rstn90(v_rstn90), .calib_start(calib_start), .rd_valid(rd_valid),
    .v_rd_data_rise(v_rd_data_rise), .v_rd_data_fall(v_rd_data_fall),
    .v_dlyinc_dq(v_dlyinc_dq), .v_dlyce_dq(v_dlyce_dq), .v_dq_oe_n(v_dq_oe_n), .v_dqs_oe_n(v_dqs_oe_n),
    .calib_busy(calib_busy), .calib_done(calib_done), .calib_fail(calib_fail), .calib_tap(calib_tap)
  );

  always #5 v_clk90 = ~v_clk90;

  typedef struct {
    bit done;
    bit fail;
    int tap;
    int incs;
    int decs;
  } exp_t;

  exp_t      sb[$];
  exp_t      mon_e;
  int        total = 0;
  int        bad = 0;
  bit [63:0] pass_mask = '0;
  bit        valid_off = 1'b0;
  int        density = 100;
  int        phy_tap = 0;
  int        n_inc = 0;
  int        n_dec = 0;
  bit        prev_busy = 1'b0;
  int        model_tap = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // NAND + PHY data source: the training pattern only at passing taps.
  initial forever begin
    @(posedge v_clk90);
    #1;
    rd_valid = !valid_off && (int'($urandom_range(0, 99)) < density);
    if (pass_mask[phy_tap]) begin
      v_rd_data_rise = PR;
      v_rd_data_fall = PF;
    end else begin
      case ($urandom_range(0, 2))
        0: begin v_rd_data_rise = PR ^ 8'($urandom_range(1, 255)); v_rd_data_fall = PF; end
        1: begin v_rd_data_rise = PR; v_rd_data_fall = PF ^ 8'($urandom_range(1, 255)); end
        default: begin
          v_rd_data_rise = PR ^ 8'($urandom_range(1, 255));
          v_rd_data_fall = PF ^ 8'($urandom_range(1, 255));
        end
      endcase
    end
  end

  // Monitor: IODELAY tap model, pulse counting, scoreboard pop when a run ends.
  initial forever begin
    @(negedge v_clk90);
    if (!v_rstn90) begin
      phy_tap   = 0;
      n_inc     = 0;
      n_dec     = 0;
      prev_busy = 1'b0;
    end else begin
      if (calib_busy && !prev_busy) begin
        n_inc = 0;
        n_dec = 0;
      end
      if (v_dlyce_dq != 8'h00) begin
        check("dlyce_uniform", int'(v_dlyce_dq == 8'hFF), 1);
        check("dlyinc_uniform", int'(v_dlyinc_dq == 8'hFF || v_dlyinc_dq == 8'h00), 1);
        check("oe_n_tristate", int'({v_dq_oe_n, v_dqs_oe_n}), 3);
        check("pulse_while_busy", int'(calib_busy), 1);
        if (v_dlyinc_dq[0]) begin
          n_inc++;
          check("tap_below_max", int'(phy_tap < MAXT), 1);
          if (phy_tap < MAXT) phy_tap++;
        end else begin
          n_dec++;
          check("tap_above_zero", int'(phy_tap > 0), 1);
          if (phy_tap > 0) phy_tap--;
        end
        check("calib_tap_track", int'(calib_tap), phy_tap);
      end
      if (!calib_busy && prev_busy) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected_end: got run end expected none");
        end else begin
          mon_e = sb.pop_front();
          check("end_done", int'(calib_done), int'(mon_e.done));
          check("end_fail", int'(calib_fail), int'(mon_e.fail));
          check("end_tap", int'(calib_tap), mon_e.tap);
          check("end_incs", n_inc, mon_e.incs);
          check("end_decs", n_dec, mon_e.decs);
        end
      end
      prev_busy = calib_busy;
    end
  end

  task automatic pulse_start();
    @(posedge v_clk90);
    #1 calib_start = 1'b1;
    @(posedge v_clk90);
    #1 calib_start = 1'b0;
  endtask

  // f<0 means no passing tap; the passing taps are exactly f..l.
  task automatic run_cal(input int f, input int l, input bit no_valid, input bit mid_start, output int cyc);
    exp_t e;
    int   end_tap;
    bit   ok;
    pass_mask = '0;
    if (f >= 0) for (int t = f; t <= l; t++) pass_mask[t] = 1'b1;
    valid_off = no_valid;
    density   = $urandom_range(40, 100);
    if (no_valid || f < 0) begin
      end_tap = no_valid ? 0 : MAXT;
      ok      = 1'b0;
    end else begin
      end_tap = (l < MAXT) ? l + 1 : MAXT;
      ok      = (l - f + 1) >= MINW;
    end
    e.done = ok;
    e.fail = !ok;
    e.tap  = ok ? (f + l) / 2 : 0;
    e.incs = end_tap;
    e.decs = model_tap + end_tap - e.tap;
    model_tap = e.tap;
    sb.push_back(e);
    pulse_start();
    cyc = 0;
    do begin
      @(negedge v_clk90);
      cyc++;
      if (mid_start && cyc == 300) calib_start = 1'b1;
      if (mid_start && cyc == 301) calib_start = 1'b0;
    end while (calib_busy === 1'b1 && cyc < 30000);
    if (cyc >= 30000) begin
      total++;
      bad++;
      $display("FAIL run_timeout: busy still %0d after %0d cycles", calib_busy, cyc);
    end
    repeat (3) @(negedge v_clk90);
    check("sticky_done", int'(calib_done), int'(e.done));
    check("sticky_fail", int'(calib_fail), int'(e.fail));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dlyce"}, int'(v_dlyce_dq), 0);
    check({tag, "_dlyinc"}, int'(v_dlyinc_dq), 0);
    check({tag, "_busy"}, int'(calib_busy), 0);
    check({tag, "_done"}, int'(calib_done), 0);
    check({tag, "_fail"}, int'(calib_fail), 0);
    check({tag, "_tap"}, int'(calib_tap), 0);
    check({tag, "_oe_n"}, int'({v_dq_oe_n, v_dqs_oe_n}), 3);
  endtask

  initial begin
    int cyc;
    int f;
    int w;
    int wait_cyc;
    @(negedge v_clk90);
    check_reset_outputs("reset");
    @(posedge v_clk90);
    #1 v_rstn90 = 1'b1;
    repeat (2) @(negedge v_clk90);

    run_cal(10, 30, 1'b0, 1'b0, cyc);
    run_cal(50, 63, 1'b0, 1'b0, cyc);
    run_cal(-1, 0, 1'b0, 1'b0, cyc);
    run_cal(20, 22, 1'b0, 1'b0, cyc);
    run_cal(10, 30, 1'b1, 1'b0, cyc);
    check("timeout_latency_ok", int'(cyc >= SETTLE + TMO && cyc <= SETTLE + TMO + 8), 1);
    run_cal(10, 30, 1'b0, 1'b0, cyc);
    run_cal(10, 30, 1'b0, 1'b1, cyc);

    for (int i = 0; i < 5; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        run_cal(-1, 0, 1'b0, 1'b0, cyc);
      end else begin
        f = $urandom_range(0, MAXT);
        w = $urandom_range(1, 12);
        run_cal(f, (f + w - 1 > MAXT) ? MAXT : f + w - 1, 1'b0, 1'b0, cyc);
      end
    end

    // Abort during centring: wait for decs after a full 10..30 sweep.
    pass_mask = '0;
    for (int t = 10; t <= 30; t++) pass_mask[t] = 1'b1;
    valid_off = 1'b0;
    density   = 100;
    pulse_start();
    wait_cyc = 0;
    do begin
      @(negedge v_clk90);
      wait_cyc++;
    end while (!(n_inc >= 31 && v_dlyce_dq != 8'h00 && v_dlyinc_dq == 8'h00 && calib_tap <= 6'd27) && wait_cyc < 20000);
    if (wait_cyc >= 20000) begin
      total++;
      bad++;
      $display("FAIL center_reached: got no centring after %0d cycles", wait_cyc);
    end
    @(posedge v_clk90);
    #1 v_rstn90 = 1'b0;
    @(negedge v_clk90);
    check_reset_outputs("mid_center_reset");
    @(posedge v_clk90);
    #1 v_rstn90 = 1'b1;
    model_tap = 0;
    repeat (3) @(negedge v_clk90);
    check("post_reset_idle_busy", int'(calib_busy), 0);

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
